// File: rtl/mips_pkg.sv
// Shared definitions for the single-cycle MIPS core.
// Contents: opcode / funct encodings, ALU operation codes, writeback and
// destination selectors, the decoded control bundle and the reset PC.
package mips_pkg;

    // Primary opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type function codes (instr[5:0])
    localparam logic [5:0] F_SLL   = 6'h00;
    localparam logic [5:0] F_SRL   = 6'h02;
    localparam logic [5:0] F_SRA   = 6'h03;
    localparam logic [5:0] F_JR    = 6'h08;
    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_ADD   = 6'h20;
    localparam logic [5:0] F_ADDU  = 6'h21;
    localparam logic [5:0] F_SUB   = 6'h22;
    localparam logic [5:0] F_SUBU  = 6'h23;
    localparam logic [5:0] F_AND   = 6'h24;
    localparam logic [5:0] F_OR    = 6'h25;
    localparam logic [5:0] F_XOR   = 6'h26;
    localparam logic [5:0] F_NOR   = 6'h27;
    localparam logic [5:0] F_SLT   = 6'h2A;
    localparam logic [5:0] F_SLTU  = 6'h2B;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    typedef enum logic [3:0] {
        AluAdd, AluSub, AluAnd, AluOr, AluXor, AluNor,
        AluSlt, AluSltu, AluSll, AluSrl, AluSra, AluLui
    } alu_op_e;

    // Register-file write address source
    typedef enum logic [1:0] {DstRt, DstRd, DstRa} dst_e;

    // Register-file write data source
    typedef enum logic [2:0] {ResAlu, ResMem, ResHi, ResLo, ResPc4} res_e;

    typedef struct packed {
        logic    reg_write;
        dst_e    dst;
        res_e    res;
        logic    alu_imm;      // ALU operand B is the extended immediate
        logic    imm_zext;     // zero- rather than sign-extend the immediate
        logic    mem_write;
        logic    beq;
        logic    bne;
        logic    jump;
        logic    jr;
        logic    hilo_write;
        logic    mult_signed;
        alu_op_e alu_op;
    } ctrl_t;

endpackage

// File: rtl/mips_controller.sv
// Main decoder and ALU decoder for the single-cycle core.
// Ports: op_i opcode; funct_i R-type function; ctrl_o decoded control bundle.
// Anything not recognised decodes to all-zero control: no writes, PC+4.
module mips_controller
    import mips_pkg::*;
(
    input  logic [5:0] op_i,
    input  logic [5:0] funct_i,
    output ctrl_t      ctrl_o
);

    always_comb begin
        ctrl_o = '0;
        case (op_i)
            OP_RTYPE: begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.dst       = DstRd;
                case (funct_i)
                    F_ADD, F_ADDU: ctrl_o.alu_op = AluAdd;
                    F_SUB, F_SUBU: ctrl_o.alu_op = AluSub;
                    F_AND:         ctrl_o.alu_op = AluAnd;
                    F_OR:          ctrl_o.alu_op = AluOr;
                    F_XOR:         ctrl_o.alu_op = AluXor;
                    F_NOR:         ctrl_o.alu_op = AluNor;
                    F_SLT:         ctrl_o.alu_op = AluSlt;
                    F_SLTU:        ctrl_o.alu_op = AluSltu;
                    F_SLL:         ctrl_o.alu_op = AluSll;
                    F_SRL:         ctrl_o.alu_op = AluSrl;
                    F_SRA:         ctrl_o.alu_op = AluSra;
                    F_MFHI:        ctrl_o.res    = ResHi;
                    F_MFLO:        ctrl_o.res    = ResLo;
                    F_JR: begin
                        ctrl_o.reg_write = 1'b0;
                        ctrl_o.jr        = 1'b1;
                    end
                    F_MULT, F_MULTU: begin
                        ctrl_o.reg_write   = 1'b0;
                        ctrl_o.hilo_write  = 1'b1;
                        ctrl_o.mult_signed = (funct_i == F_MULT);
                    end
                    default: ctrl_o.reg_write = 1'b0;
                endcase
            end
            OP_ADDI, OP_ADDIU: begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.alu_imm   = 1'b1;
            end
            OP_SLTI: begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.alu_imm   = 1'b1;
                ctrl_o.alu_op    = AluSlt;
            end
            OP_ANDI, OP_ORI, OP_XORI: begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.alu_imm   = 1'b1;
                ctrl_o.imm_zext  = 1'b1;
                ctrl_o.alu_op    = (op_i == OP_ANDI) ? AluAnd :
                                   (op_i == OP_ORI)  ? AluOr  : AluXor;
            end
            OP_LUI: begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.alu_imm   = 1'b1;
                ctrl_o.imm_zext  = 1'b1;
                ctrl_o.alu_op    = AluLui;
            end
            OP_LW: begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.alu_imm   = 1'b1;
                ctrl_o.res       = ResMem;
            end
            OP_SW: begin
                ctrl_o.alu_imm   = 1'b1;
                ctrl_o.mem_write = 1'b1;
            end
            OP_BEQ: ctrl_o.beq  = 1'b1;
            OP_BNE: ctrl_o.bne  = 1'b1;
            OP_J:   ctrl_o.jump = 1'b1;
            OP_JAL: begin
                ctrl_o.jump      = 1'b1;
                ctrl_o.reg_write = 1'b1;
                ctrl_o.dst       = DstRa;
                ctrl_o.res       = ResPc4;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mips_core.sv
// Single-cycle MIPS core: controller plus datapath, memories outside.
// Ports: clk_i/reset_i clock and synchronous active-high reset; instr_i fetched
//        word; imem_idx_o fetch index; dmem_idx_o/mem_we_o/mem_wdata_o data
//        RAM access; mem_rdata_i data RAM read data.
module mips_core
    import mips_pkg::*;
#(
    parameter int unsigned IMEM_AW = 6,
    parameter int unsigned DMEM_AW = 6
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic [31:0]        instr_i,
    input  logic [31:0]        mem_rdata_i,
    output logic [IMEM_AW-1:0] imem_idx_o,
    output logic [DMEM_AW-1:0] dmem_idx_o,
    output logic               mem_we_o,
    output logic [31:0]        mem_wdata_o
);

    ctrl_t ctrl;

    mips_controller controller (
        .op_i    (instr_i[31:26]),
        .funct_i (instr_i[5:0]),
        .ctrl_o  (ctrl)
    );

    mips_datapath #(
        .IMEM_AW (IMEM_AW),
        .DMEM_AW (DMEM_AW)
    ) dp (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .ctrl_i      (ctrl),
        .instr_i     (instr_i[25:0]),
        .mem_rdata_i (mem_rdata_i),
        .imem_idx_o  (imem_idx_o),
        .dmem_idx_o  (dmem_idx_o),
        .mem_wdata_o (mem_wdata_o)
    );

    assign mem_we_o = ctrl.mem_write;

endmodule

// File: rtl/mips_datapath.sv
// Datapath: PC, register file, ALU, multiplier with HI/LO, writeback mux.
// Ports: clk_i/reset_i clock and synchronous active-high reset; ctrl_i decoded
//        control; instr_i low 26 instruction bits; mem_rdata_i data RAM read;
//        imem_idx_o fetch word index; dmem_idx_o data word index;
//        mem_wdata_o store data.
module mips_datapath
    import mips_pkg::*;
#(
    parameter int unsigned IMEM_AW = 6,
    parameter int unsigned DMEM_AW = 6
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  ctrl_t              ctrl_i,
    input  logic [25:0]        instr_i,
    input  logic [31:0]        mem_rdata_i,
    output logic [IMEM_AW-1:0] imem_idx_o,
    output logic [DMEM_AW-1:0] dmem_idx_o,
    output logic [31:0]        mem_wdata_o
);

    logic [4:0]  rs, rt, rd, shamt;
    logic [15:0] imm;
    logic [31:0] pc_q, pc_d, hi_q, hi_d, lo_q, lo_d;
    logic [31:0] rs_data, rt_data, simm, imm_ext, src_b, alu_result, wb_data;
    logic [31:0] pc_plus4, branch_target;
    logic [4:0]  wb_addr;
    logic [63:0] product;
    logic        take_branch;

    assign rs    = instr_i[25:21];
    assign rt    = instr_i[20:16];
    assign rd    = instr_i[15:11];
    assign shamt = instr_i[10:6];
    assign imm   = instr_i[15:0];

    assign simm    = {{16{imm[15]}}, imm};
    assign imm_ext = ctrl_i.imm_zext ? {16'd0, imm} : simm;
    assign src_b   = ctrl_i.alu_imm ? imm_ext : rt_data;

    mips_regfile gpr (
        .clk_i (clk_i),
        .we_i  (ctrl_i.reg_write),
        .wa_i  (wb_addr),
        .wd_i  (wb_data),
        .ra1_i (rs),
        .ra2_i (rt),
        .rd1_o (rs_data),
        .rd2_o (rt_data)
    );

    // ALU; shifts take rt through src_b and the amount from shamt
    always_comb begin
        alu_result = 32'd0;
        case (ctrl_i.alu_op)
            AluAdd:  alu_result = rs_data + src_b;
            AluSub:  alu_result = rs_data - src_b;
            AluAnd:  alu_result = rs_data & src_b;
            AluOr:   alu_result = rs_data | src_b;
            AluXor:  alu_result = rs_data ^ src_b;
            AluNor:  alu_result = ~(rs_data | src_b);
            AluSlt:  alu_result = {31'd0, $signed(rs_data) < $signed(src_b)};
            AluSltu: alu_result = {31'd0, rs_data < src_b};
            AluSll:  alu_result = src_b << shamt;
            AluSrl:  alu_result = src_b >> shamt;
            AluSra:  alu_result = $signed(src_b) >>> shamt;
            AluLui:  alu_result = {src_b[15:0], 16'd0};
            default: alu_result = 32'd0;
        endcase
    end

    // Operands widened by hand so a plain 64-bit multiply gives either product
    always_comb begin
        if (ctrl_i.mult_signed) begin
            product = {{32{rs_data[31]}}, rs_data} * {{32{rt_data[31]}}, rt_data};
        end else begin
            product = {32'd0, rs_data} * {32'd0, rt_data};
        end
        hi_d = ctrl_i.hilo_write ? product[63:32] : hi_q;
        lo_d = ctrl_i.hilo_write ? product[31:0]  : lo_q;
    end

    always_comb begin
        wb_addr = rt;
        case (ctrl_i.dst)
            DstRd:   wb_addr = rd;
            DstRa:   wb_addr = 5'd31;
            default: wb_addr = rt;
        endcase
        wb_data = alu_result;
        case (ctrl_i.res)
            ResMem:  wb_data = mem_rdata_i;
            ResHi:   wb_data = hi_q;
            ResLo:   wb_data = lo_q;
            ResPc4:  wb_data = pc_plus4;
            default: wb_data = alu_result;
        endcase
    end

    always_comb begin
        pc_plus4      = pc_q + 32'd4;
        branch_target = pc_plus4 + {simm[29:0], 2'b00};
        take_branch   = (ctrl_i.beq && (rs_data == rt_data)) ||
                        (ctrl_i.bne && (rs_data != rt_data));
        if (ctrl_i.jr) begin
            pc_d = rs_data;
        end else if (ctrl_i.jump) begin
            pc_d = {pc_plus4[31:28], instr_i, 2'b00};
        end else if (take_branch) begin
            pc_d = branch_target;
        end else begin
            pc_d = pc_plus4;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            pc_q <= RESET_PC;
            hi_q <= 32'd0;
            lo_q <= 32'd0;
        end else begin
            pc_q <= pc_d;
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

    assign imem_idx_o  = pc_q[IMEM_AW+1:2];
    assign dmem_idx_o  = alu_result[DMEM_AW+1:2];
    assign mem_wdata_o = rt_data;

endmodule

// File: rtl/mips_dmem.sv
// Word-addressed data RAM: combinational read, write on rising edge, no reset.
// Ports: clk_i clock; we_i write enable; idx_i word index; wdata_i write data;
//        rdata_o read data.
module mips_dmem #(
    parameter int unsigned WORDS = 64,
    parameter int unsigned AW    = 6
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] idx_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem [WORDS];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[idx_i] <= wdata_i;
        end
    end

    assign rdata_o = mem[idx_i];

endmodule

// File: rtl/mips_imem.sv
// Instruction ROM, contents loaded from outside the design.
// Ports: idx_i word index; instr_o combinational instruction word.
module mips_imem #(
    parameter int unsigned WORDS = 64,
    parameter int unsigned AW    = 6
) (
    input  logic [AW-1:0] idx_i,
    output logic [31:0]   instr_o
);

    logic [31:0] INSTRROM [WORDS];

    assign instr_o = INSTRROM[idx_i];

endmodule

// File: rtl/mips_regfile.sv
// 32 x 32-bit general-purpose register file.
// Ports: clk_i clock; we_i write enable; wa_i/wd_i write address/data;
//        ra1_i/ra2_i read addresses; rd1_o/rd2_o combinational read data.
// $0 is not stored: it always reads zero and writes to it are dropped.
// No reset, so contents preloaded before start are kept.
module mips_regfile (
    input  logic        clk_i,
    input  logic        we_i,
    input  logic [4:0]  wa_i,
    input  logic [31:0] wd_i,
    input  logic [4:0]  ra1_i,
    input  logic [4:0]  ra2_i,
    output logic [31:0] rd1_o,
    output logic [31:0] rd2_o
);

    logic [31:0] registers [1:31];

    always_ff @(posedge clk_i) begin
        if (we_i && (wa_i != 5'd0)) begin
            registers[wa_i] <= wd_i;
        end
    end

    assign rd1_o = (ra1_i == 5'd0) ? 32'd0 : registers[ra1_i];
    assign rd2_o = (ra2_i == 5'd0) ? 32'd0 : registers[ra2_i];

endmodule

// File: rtl/mips_single_cycle_processor.sv
// Top level: single-cycle MIPS core with instruction ROM and data RAM.
// Ports: clk single clock (rising edge); reset synchronous, active-high.
// No data ports: results live in the register file and memories.
module mips_single_cycle_processor #(
    parameter int unsigned IMEM_WORDS = 64,
    parameter int unsigned DMEM_WORDS = 64
) (
    input logic clk,
    input logic reset
);

    localparam int unsigned IMEM_AW = (IMEM_WORDS > 1) ? $clog2(IMEM_WORDS) : 1;
    localparam int unsigned DMEM_AW = (DMEM_WORDS > 1) ? $clog2(DMEM_WORDS) : 1;

    logic [IMEM_AW-1:0] imem_idx;
    logic [DMEM_AW-1:0] dmem_idx;
    logic [31:0]        instr, mem_rdata, mem_wdata;
    logic               mem_we;

    mips_imem #(
        .WORDS (IMEM_WORDS),
        .AW    (IMEM_AW)
    ) imem (
        .idx_i   (imem_idx),
        .instr_o (instr)
    );

    mips_dmem #(
        .WORDS (DMEM_WORDS),
        .AW    (DMEM_AW)
    ) dmem (
        .clk_i   (clk),
        .we_i    (mem_we),
        .idx_i   (dmem_idx),
        .wdata_i (mem_wdata),
        .rdata_o (mem_rdata)
    );

    mips_core #(
        .IMEM_AW (IMEM_AW),
        .DMEM_AW (DMEM_AW)
    ) mips (
        .clk_i       (clk),
        .reset_i     (reset),
        .instr_i     (instr),
        .mem_rdata_i (mem_rdata),
        .imem_idx_o  (imem_idx),
        .dmem_idx_o  (dmem_idx),
        .mem_we_o    (mem_we),
        .mem_wdata_o (mem_wdata)
    );

endmodule

// File: tb/tb_mips_single_cycle_processor.sv
// Directed bench: loads a program into the ROM, runs it, and compares
// architectural state (GPRs, PC, HI, LO) against expected values queued
// before each observation point.
module tb_mips_single_cycle_processor;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    int n_cmp  = 0;
    int n_fail = 0;

    // Scoreboard: index 1..31 = GPR, 32 = PC, 33 = HI, 34 = LO
    string       tag_q[$];
    int          idx_q[$];
    logic [31:0] val_q[$];

    mips_single_cycle_processor #(
        .IMEM_WORDS (64),
        .DMEM_WORDS (64)
    ) dut (
        .clk   (clk),
        .reset (reset)
    );

    always #2 clk = ~clk;

    task automatic put(input int addr, input logic [31:0] word);
        dut.imem.INSTRROM[addr >> 2] = word;
    endtask

    task automatic expect_val(input string tag, input int idx, input logic [31:0] val);
        tag_q.push_back(tag);
        idx_q.push_back(idx);
        val_q.push_back(val);
    endtask

    function automatic logic [31:0] observe(input int idx);
        if (idx == 32) return dut.mips.dp.pc_q;
        if (idx == 33) return dut.mips.dp.hi_q;
        if (idx == 34) return dut.mips.dp.lo_q;
        return dut.mips.dp.gpr.registers[idx];
    endfunction

    task automatic drain();
        while (tag_q.size() > 0) begin
            string       tag;
            int          idx;
            logic [31:0] exp_v;
            logic [31:0] obs;
            tag   = tag_q.pop_front();
            idx   = idx_q.pop_front();
            exp_v = val_q.pop_front();
            obs   = observe(idx);
            n_cmp++;
            assert (obs === exp_v) else begin
                n_fail++;
                $error("FAIL %s: observed %08h expected %08h", tag, obs, exp_v);
            end
        end
    endtask

    task automatic run_edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) dut.imem.INSTRROM[i] = 32'h0;
        for (int i = 1; i < 32; i++) dut.mips.dp.gpr.registers[i] = 32'h0;

        put(32'h00, 32'h2001_0005);  // addi $1,$0,5
        put(32'h04, 32'h2022_FFF9);  // addi $2,$1,-7
        put(32'h08, 32'h0C00_000C);  // jal  0x30
        put(32'h0C, 32'h0022_1822);  // sub  $3,$1,$2
        put(32'h10, 32'h3C04_1234);  // lui  $4,0x1234
        put(32'h14, 32'h3484_5678);  // ori  $4,$4,0x5678
        put(32'h18, 32'h0800_0010);  // j    0x40
        put(32'h30, 32'hAC02_0010);  // sw   $2,16($0)
        put(32'h34, 32'h8C09_0010);  // lw   $9,16($0)
        put(32'h38, 32'h03E0_0008);  // jr   $31
        put(32'h40, 32'h2005_0007);  // addi $5,$0,7
        put(32'h44, 32'h2006_FFFD);  // addi $6,$0,-3
        put(32'h48, 32'h00A6_0018);  // mult $5,$6
        put(32'h4C, 32'h0000_3812);  // mflo $7
        put(32'h50, 32'h0000_4010);  // mfhi $8
        put(32'h54, 32'h200A_FFFF);  // addi $10,$0,-1
        put(32'h58, 32'h200B_0002);  // addi $11,$0,2
        put(32'h5C, 32'h014B_0019);  // multu $10,$11
        put(32'h60, 32'h0000_6012);  // mflo $12
        put(32'h64, 32'h0000_6810);  // mfhi $13
        put(32'h68, 32'h1000_0001);  // beq  $0,$0,+1
        put(32'h6C, 32'h200E_0001);  // addi $14,$0,1 (skipped)
        put(32'h70, 32'h1400_0001);  // bne  $0,$0,+1 (not taken)
        put(32'h74, 32'h200F_0003);  // addi $15,$0,3
        put(32'h78, 32'h2000_0009);  // addi $0,$0,9
        put(32'h7C, 32'h2010_0000);  // addi $16,$0,0
        put(32'h80, 32'h2011_0001);  // addi $17,$0,1
        put(32'h84, 32'h2012_000A);  // addi $18,$0,10
        put(32'h88, 32'h0211_9820);  // loop: add $19,$16,$17
        put(32'h8C, 32'h0220_8020);  // add  $16,$17,$0
        put(32'h90, 32'h0260_8820);  // add  $17,$19,$0
        put(32'h94, 32'h2252_FFFF);  // addi $18,$18,-1
        put(32'h98, 32'h1640_FFFB);  // bne  $18,$0,loop
        put(32'h9C, 32'h0800_0027);  // halt: j halt

        // Reset edge
        run_edges(1);
        reset = 1'b0;
        expect_val("reset_pc", 32, 32'h0);
        expect_val("reset_hi", 33, 32'h0);
        expect_val("reset_lo", 34, 32'h0);
        drain();

        // 27 edges of straight-line code plus three loop iterations
        run_edges(42);
        expect_val("mid_pc",    32, 32'h0000_0088);
        expect_val("mid_r1",     1, 32'h0000_0005);
        expect_val("mid_r2",     2, 32'hFFFF_FFFE);
        expect_val("mid_r3",     3, 32'h0000_0007);
        expect_val("mid_r31",   31, 32'h0000_000C);
        expect_val("mid_r16",   16, 32'h0000_0002);
        expect_val("mid_r17",   17, 32'h0000_0003);
        expect_val("mid_r18",   18, 32'h0000_0007);
        expect_val("mid_hi",    33, 32'h0000_0001);
        expect_val("mid_lo",    34, 32'hFFFF_FFFE);
        drain();

        // One-edge reset in the middle of the loop
        reset = 1'b1;
        run_edges(1);
        reset = 1'b0;
        expect_val("rst2_pc",   32, 32'h0);
        expect_val("rst2_hi",   33, 32'h0);
        expect_val("rst2_lo",   34, 32'h0);
        expect_val("rst2_r16",  16, 32'h0000_0002);
        expect_val("rst2_r17",  17, 32'h0000_0003);
        expect_val("rst2_r18",  18, 32'h0000_0007);
        drain();

        // Rerun to the halt loop
        run_edges(100);
        expect_val("fin_pc",    32, 32'h0000_009C);
        expect_val("fin_r1",     1, 32'h0000_0005);
        expect_val("fin_r2",     2, 32'hFFFF_FFFE);
        expect_val("fin_r3",     3, 32'h0000_0007);
        expect_val("fin_r4",     4, 32'h1234_5678);
        expect_val("fin_r5",     5, 32'h0000_0007);
        expect_val("fin_r6",     6, 32'hFFFF_FFFD);
        expect_val("mult_lo_r7", 7, 32'hFFFF_FFEB);
        expect_val("mult_hi_r8", 8, 32'hFFFF_FFFF);
        expect_val("lw_r9",      9, 32'hFFFF_FFFE);
        expect_val("multu_lo",  12, 32'hFFFF_FFFE);
        expect_val("multu_hi",  13, 32'h0000_0001);
        expect_val("skip_r14",  14, 32'h0000_0000);
        expect_val("bne_nt_r15", 15, 32'h0000_0003);
        expect_val("fib_r16",   16, 32'h0000_0037);
        expect_val("fib_r17",   17, 32'h0000_0059);
        expect_val("fib_r18",   18, 32'h0000_0000);
        expect_val("fib_r19",   19, 32'h0000_0059);
        expect_val("jal_r31",   31, 32'h0000_000C);
        expect_val("fin_hi",    33, 32'h0000_0001);
        expect_val("fin_lo",    34, 32'hFFFF_FFFE);
        expect_val("idle_r20",  20, 32'h0);
        expect_val("idle_r25",  25, 32'h0);
        expect_val("idle_r30",  30, 32'h0);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
